// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// fifo_pkg : shared types, default sizing and helpers for the FIFO write path
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int DEF_DSIZE_IN = 8;
  localparam int DEF_RATIO    = 4;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } wr_state_e;

  // Lane index width; never narrower than one bit so RATIO=2 still has a counter.
  function automatic int lane_idx_w(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_slice.sv
//------------------------------------------------------------------------------
// fifo_wr_slice : one-word output holding register driving the FIFO write port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wr_slice
  import fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE_IN * DEF_RATIO,
  parameter int RATIO = DEF_RATIO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DSIZE-1:0] i_data,
  input  logic [RATIO-1:0] i_keep,
  input  logic             i_wfull,
  output logic             o_winc,
  output logic             o_free,
  output logic [DSIZE-1:0] o_wdata,
  output logic [RATIO-1:0] o_wkeep
);

  logic             r_vld;
  logic [DSIZE-1:0] r_data;
  logic [RATIO-1:0] r_keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_keep <= '0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
      r_keep <= i_keep;
    end else if (o_winc) begin
      r_vld  <= 1'b0;
    end
  end

  // Free also covers "draining this edge", so a new word can land back-to-back.
  assign o_winc  = r_vld & ~i_wfull;
  assign o_free  = ~r_vld | ~i_wfull;
  assign o_wdata = r_data;
  assign o_wkeep = r_keep;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_packer.sv
//------------------------------------------------------------------------------
// fifo_wr_packer : packs RATIO narrow beats per FIFO word; FIFO_WR_PACKER_STAT_EN
// adds wr_cnt/part_cnt write statistics.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int DSIZE_IN = DEF_DSIZE_IN,
  parameter int RATIO    = DEF_RATIO
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DSIZE_IN-1:0]       in_data,
  input  logic                      in_last,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DSIZE_IN*RATIO-1:0] wdata,
  output logic [RATIO-1:0]          wkeep
`ifdef FIFO_WR_PACKER_STAT_EN
  ,
  output logic [15:0]               wr_cnt,
  output logic [15:0]               part_cnt
`endif
);

  localparam int DSIZE = DSIZE_IN * RATIO;
  localparam int CW    = lane_idx_w(RATIO);
  localparam logic [CW-1:0] C_LAST_LANE = CW'(RATIO - 1);

  wr_state_e        r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [DSIZE-1:0] r_acc, w_acc_nxt, w_word, w_load_data;
  logic [RATIO-1:0] r_keep, w_keep_nxt, w_word_keep, w_load_keep;
  logic             w_accept, w_done, w_free, w_load;

  assign in_ready = (r_state == ST_FILL);
  assign w_accept = in_valid & in_ready;
  assign w_done   = w_accept & ((r_cnt == C_LAST_LANE) | in_last);

  // Accumulator with the incoming beat merged into lane r_cnt.
  always_comb begin
    w_word      = r_acc;
    w_word_keep = r_keep;
    for (int l = 0; l < RATIO; l++) begin
      if (r_cnt == CW'(l)) begin
        w_word[l*DSIZE_IN +: DSIZE_IN] = in_data;
        w_word_keep[l]                 = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_keep_nxt  = r_keep;
    w_load      = 1'b0;
    w_load_data = w_word;
    w_load_keep = w_word_keep;
    case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          if (w_done) begin
            w_cnt_nxt = '0;
            if (w_free) begin
              w_load     = 1'b1;
              w_acc_nxt  = '0;
              w_keep_nxt = '0;
            end else begin
              // Park the completed word in the accumulator until the slice frees up.
              w_acc_nxt   = w_word;
              w_keep_nxt  = w_word_keep;
              w_state_nxt = ST_HOLD;
            end
          end else begin
            w_cnt_nxt  = r_cnt + CW'(1);
            w_acc_nxt  = w_word;
            w_keep_nxt = w_word_keep;
          end
        end
      end
      ST_HOLD: begin
        w_load_data = r_acc;
        w_load_keep = r_keep;
        if (w_free) begin
          w_load      = 1'b1;
          w_acc_nxt   = '0;
          w_keep_nxt  = '0;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_keep  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_keep  <= w_keep_nxt;
    end
  end

  fifo_wr_slice #(
    .DSIZE (DSIZE),
    .RATIO (RATIO)
  ) u_slice (
    .clk     (wclk),
    .rst     (wrst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_keep  (w_load_keep),
    .i_wfull (wfull),
    .o_winc  (winc),
    .o_free  (w_free),
    .o_wdata (wdata),
    .o_wkeep (wkeep)
  );

`ifdef FIFO_WR_PACKER_STAT_EN
  logic [15:0] r_wr_cnt, r_part_cnt;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_wr_cnt   <= '0;
      r_part_cnt <= '0;
    end else if (winc) begin
      r_wr_cnt <= r_wr_cnt + 16'd1;
      if (wkeep != '1) begin
        r_part_cnt <= r_part_cnt + 16'd1;
      end
    end
  end

  assign wr_cnt   = r_wr_cnt;
  assign part_cnt = r_part_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_packer.sv
//------------------------------------------------------------------------------
// tb_fifo_wr_packer : directed, table-driven bench for fifo_wr_packer (RATIO=4, 8-bit beats)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_packer;

  logic        clk;
  logic        wrst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        wfull;
  logic        winc;
  logic [31:0] wdata;
  logic [3:0]  wkeep;
`ifdef FIFO_WR_PACKER_STAT_EN
  logic [15:0] wr_cnt;
  logic [15:0] part_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fifo_wr_packer #(
    .DSIZE_IN (8),
    .RATIO    (4)
  ) dut (
    .wclk     (clk),
    .wrst     (wrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .wkeep    (wkeep)
`ifdef FIFO_WR_PACKER_STAT_EN
    ,
    .wr_cnt   (wr_cnt),
    .part_cnt (part_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One row = inputs for a cycle plus the outputs expected during that cycle (before its edge).
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        wf;
    logic        rdy;
    logic        winc;
    logic [31:0] wdata;
    logic [3:0]  wkeep;
    logic [15:0] wr;
    logic [15:0] part;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 16'd0, 16'd0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 16'd0, 16'd0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 16'd0, 16'd0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 16'd0, 16'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 16'd0, 16'd0};
    tbl[5] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 16'd1, 16'd0};
    tbl[6] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 16'd1, 16'd0};
    tbl[7] = '{1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000A2A1, 4'h3, 16'd1, 16'd0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000B0, 4'h1, 16'd2, 16'd1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 16'd3, 16'd2};

    wrst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; wfull = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wrst = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_winc",  winc,     0);
    chk("rst_wdata", wdata,    0);
    chk("rst_wkeep", wkeep,    0);

    // Full word, short word with in_last, single-lane word.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l; wfull = tbl[i].wf;
      #1;
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_winc", i),  winc,     tbl[i].winc);
      if (tbl[i].winc) begin
        chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].wdata);
        chk($sformatf("tbl%0d_wkeep", i), wkeep, tbl[i].wkeep);
      end
`ifdef FIFO_WR_PACKER_STAT_EN
      chk($sformatf("tbl%0d_wr_cnt", i),   wr_cnt,   tbl[i].wr);
      chk($sformatf("tbl%0d_part_cnt", i), part_cnt, tbl[i].part);
`endif
    end

    // Two words of back-pressure under wfull, then back-to-back drain.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(i + 1); in_last = 1'b0; wfull = 1'b1;
      #1;
      chk($sformatf("full_beat%0d_ready", i), in_ready, 1);
      chk($sformatf("full_beat%0d_winc", i),  winc,     0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_ready_low", in_ready, 0);
    chk("full_no_winc",   winc,     0);
    @(negedge clk);
    #1;
    chk("full_ready_low2", in_ready, 0);
    chk("full_no_winc2",   winc,     0);
    @(negedge clk);
    wfull = 1'b0;
    #1;
    chk("drain0_winc",  winc,  1);
    chk("drain0_wdata", wdata, 32'h04030201);
    chk("drain0_wkeep", wkeep, 4'hF);
    @(negedge clk);
    #1;
    chk("drain1_winc",  winc,     1);
    chk("drain1_wdata", wdata,    32'h08070605);
    chk("drain1_wkeep", wkeep,    4'hF);
    chk("drain1_ready", in_ready, 1);
    @(negedge clk);
    #1;
    chk("drain2_winc", winc, 0);

    // Reset while holding two words must discard them.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i); wfull = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; wfull = 1'b0; wrst = 1'b1;
    @(negedge clk);
    wrst = 1'b0;
    #1;
    chk("hold_rst_ready", in_ready, 1);
    chk("hold_rst_winc",  winc,     0);
    @(negedge clk);
    #1;
    chk("hold_rst_winc2", winc, 0);

    // Reset mid-word, then a fresh word starts at lane 0.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hD1;
    @(negedge clk);
    in_data = 8'hD2;
    @(negedge clk);
    in_valid = 1'b0; wrst = 1'b1;
    @(negedge clk);
    wrst = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_winc",  winc,     0);
    chk("midrst_wdata", wdata,    0);
    chk("midrst_wkeep", wkeep,    0);
`ifdef FIFO_WR_PACKER_STAT_EN
    chk("midrst_wr_cnt",   wr_cnt,   0);
    chk("midrst_part_cnt", part_cnt, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hC1 + 8'(i);
      #1;
      chk($sformatf("c_beat%0d_winc", i), winc, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("c_word_winc",  winc,  1);
    chk("c_word_wdata", wdata, 32'hC4C3C2C1);
    chk("c_word_wkeep", wkeep, 4'hF);

    // Sustained one-beat-per-cycle throughput.
    begin
      int npulse;
      int last_p;
      npulse = 0;
      last_p = -1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        in_valid = (i < 16); in_data = 8'(i); in_last = 1'b0; wfull = 1'b0;
        #1;
        if (i < 16) chk($sformatf("burst%0d_ready", i), in_ready, 1);
        chk($sformatf("burst%0d_winc", i), winc, (i >= 4 && i % 4 == 0 && i <= 16));
        if (winc && i >= 4) begin
          npulse++;
          chk($sformatf("burst%0d_wdata", i), wdata,
              {8'(i - 1), 8'(i - 2), 8'(i - 3), 8'(i - 4)});
          if (last_p >= 0) chk($sformatf("burst%0d_spacing", i), i - last_p, 4);
          last_p = i;
        end
      end
      chk("burst_npulse", npulse, 4);
    end

`ifdef FIFO_WR_PACKER_STAT_EN
    @(negedge clk);
    #1;
    chk("stat_pre_wr_cnt", wr_cnt, 5);
    wrst = 1'b1;
    @(negedge clk);
    wrst = 1'b0;
    #1;
    chk("stat_rst_wr_cnt",   wr_cnt,   0);
    chk("stat_rst_part_cnt", part_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side ingress stage of the asynchronous FIFO, in the write clock domain, directly upstream of the write-pointer/full-flag logic. Accepts narrow beats on a valid/ready stream, packs `RATIO` beats into one FIFO word, and drives the FIFO write port (`winc`, `wdata`, `wkeep`). It honours `wfull` so no write is issued into a full FIFO. Upstream stalls only when both internal word registers are occupied.

## Interface
- `DSIZE_IN`, 8: width of one input beat.
- `RATIO`, 4: beats per FIFO word, ≥2. FIFO word width `DSIZE = DSIZE_IN*RATIO`.
- `wclk`  in  1  write-domain clock, all logic on rising edge.
- `wrst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_data`  in  DSIZE_IN  beat payload.
- `in_last`  in  1  beat closes the current word early (packet end).
- `wfull`  in  1  FIFO full flag from the write-pointer/full logic.
- `winc`  out  1  FIFO write strobe.
- `wdata`  out  DSIZE  FIFO word; lane 0 = bits [DSIZE_IN-1:0].
- `wkeep`  out  RATIO  per-lane valid mask stored alongside `wdata`.

## Operation
- Beat accepted when `in_valid & in_ready`. It is written into accumulator lane `cnt`. Lanes fill little-endian from lane 0.
- `cnt` is `$clog2(RATIO)` bits. Word completes on accept when `cnt==RATIO-1` or `in_last=1`. `cnt` then returns to 0; otherwise `cnt+1`.
- Unfilled lanes of a completed word read as zero, with their `wkeep` bits 0. `wkeep` of a full word is all ones.
- Output register (`out_vld`, `wdata`, `wkeep`) holds one complete word.
- `winc = out_vld & ~wfull` (combinational; `wfull` is registered upstream). A write is consumed on each edge with `winc=1`.
- Accumulator states:
  - FILL: collecting beats.
  - HOLD: completed word waiting because the output register is occupied and not draining.
- Transitions:
  - FILL→FILL: beat completes a word and the output register is free or draining this cycle. The word moves into the output register on the same edge.
  - FILL→HOLD: beat completes a word and the output register is busy and not draining.
  - HOLD→FILL: on the edge where the output register is free or draining. The held word moves to the output register.
- `in_ready = (state==FILL)`. It is registered state only and has no combinational path from `in_valid`.
- Order of words and beats is strictly preserved. Data is never dropped or duplicated.
- Reset (`wrst=1` at an edge), including mid-word or mid-hold:
  - `state=FILL`, `cnt=0`, accumulator lanes cleared.
  - `out_vld=0`, so `winc=0`, `wdata=0` and `wkeep=0`.
  - Reset state is `in_ready=1`.
  - Partial words are discarded.
- `in_last` on lane 0 produces a single-lane word with `wkeep=1`.

## Timing
- Latency: a completing beat accepted at edge E with the output register free gives `winc=1` in the cycle after E when `wfull=0`.
- Throughput: one beat per cycle sustained with `wfull=0`; one FIFO write per `RATIO` beats.
- With `wfull=1`:
  - The output register holds and the accumulator keeps filling.
  - On completion the accumulator enters HOLD and `in_ready` drops the next cycle.
  - Total stall capacity is 2 words.
- When `wfull` falls, `winc` rises in the same cycle. The held word advances on that edge, so writes occur in consecutive cycles.

## Configuration
- `FIFO_WR_PACKER_STAT_EN` defined:
  - Adds output `wr_cnt[15:0]`, which increments on every edge with `winc=1` and wraps at 0xFFFF→0.
  - Adds output `part_cnt[15:0]`, which counts written words whose `wkeep` is not all ones and also wraps.
  - Both are 0 after reset.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - FILL/HOLD state enum.
  - Default `DSIZE_IN`/`RATIO` constants.
  - Lane-index width helper.
- Sub-module `fifo_wr_slice`: the output holding register. It takes a word plus keep and valid, takes `wfull`, and produces `winc` and a free/draining indication. Accumulator and FSM stay in the top.

## Test plan
- RATIO=4, DSIZE_IN=8, `wfull=0`. Beats 0x11,0x22,0x33,0x44 → one `winc` pulse, `wdata=0x44332211`, `wkeep=4'b1111`.
- Beats 0xA1, then 0xA2 with `in_last=1` → `wdata=0x0000A2A1`, `wkeep=4'b0011`. Next beat 0xB0 lands in lane 0.
- `wfull=1`, 8 beats 0x01..0x08 offered continuously:
  - All 8 accepted; `in_ready=0` from the cycle after the 8th; no `winc`.
  - Drop `wfull` → `winc` in two consecutive cycles with `wdata` 0x04030201 then 0x08070605.
- Two beats accepted, then `wrst=1` for one cycle → no `winc` and `in_ready=1`. The next 4 beats 0xC1..0xC4 produce `wdata=0xC4C3C2C1`.
- 16 continuous beats with `wfull=0` → `in_ready` never deasserts, and 4 `winc` pulses occur exactly 4 cycles apart.
- With `FIFO_WR_PACKER_STAT_EN`: after tests 1–2 without reset, `wr_cnt=2` and `part_cnt=1`. Reset returns both to 0.
